serial_addsub: RTL

- Parametrised, digit-serial adder/subtractor; generational successor to the team's 4-bit ripple-carry adder.
- Processes a WIDTH-bit operand pair DIGIT bits per clock through one DIGIT-bit full-adder chain.
- Adds subtract mode, carry chaining, status flags and valid/ready handshakes on both sides.
- Sits between the operand register file and the ALU result mux; used where area beats latency.

---
 rtl/serial_addsub.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock through one
// shared DIGIT-bit adder. Valid/ready handshakes on both sides, result and flags registered.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_full;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_cin_msb;
  logic             w_last;
  logic [WIDTH-1:0] w_y_full;

  // Operands shift right one digit per cycle, so the active digit is always the low slice.
  assign w_a_dig = r_a[DIGIT-1:0];
  assign w_b_dig = r_b[DIGIT-1:0];
  assign w_last  = (r_cnt == CNT_W'(N - 1));

  // NOTE: every variable assigned in always_comb gets a value on every path; a missed
  // path would infer a latch.
  always_comb begin
    w_full    = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
    w_sum     = w_full[DIGIT-1:0];
    w_cout    = w_full[DIGIT];
    // Carry into the digit's MSB recovered from the MSB sum bit.
    w_cin_msb = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_sum[DIGIT-1];
    // New digit enters at the top; after N digits digit 0 has reached bit 0.
    w_y_full  = (r_sh >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sh      <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= mode ? ~b : b;
            r_carry  <= carry_in;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sh    <= w_y_full;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            y         <= w_y_full;
            carry_out <= w_cout;
            overflow  <= w_cin_msb ^ w_cout;
            zero      <= (w_y_full == '0);
            negative  <= w_y_full[WIDTH-1];
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
